// File: rtl/pfb_pkg.sv
// Shared constants and helpers for the polyphase filter bank datapath.
// Phase-count clamping lives here so every PFB block agrees on legal M.
package pfb_pkg;

    localparam int PFB_PHASE_W    = 11;
    localparam int PFB_SAMP_W     = 32;
    localparam int PFB_MAX_PHASES = 2048;

    // Legal arm counts are 2 .. PFB_MAX_PHASES.
    function automatic logic [11:0] clamp_phases(input logic [11:0] n);
        if (n < 12'd2)
            return 12'd2;
        else if (n > 12'(PFB_MAX_PHASES))
            return 12'(PFB_MAX_PHASES);
        else
            return n;
    endfunction

endpackage

// File: rtl/pfb_input_commutator_skid.sv
// Two-entry AXI-Stream register slice (main + skid) with registered ready.
// Reusable at any stream boundary that needs full throughput and no comb path.
module axis_skid_2 #(
    parameter int WIDTH = 44
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
);

    logic             main_v;
    logic             skid_v;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic             accept;

    assign accept  = s_valid & s_ready;
    assign m_valid = main_v;
    assign m_data  = main_d;

    // Main/skid occupancy; ready drops only while skid holds a beat.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            main_v  <= 1'b0;
            skid_v  <= 1'b0;
            main_d  <= '0;
            skid_d  <= '0;
            s_ready <= 1'b0;
        end else begin
            if (!main_v || m_ready) begin
                if (skid_v) begin
                    main_d <= skid_d;
                    main_v <= 1'b1;
                    skid_v <= 1'b0;
                end else begin
                    main_v <= accept;
                    if (accept)
                        main_d <= s_data;
                end
            end else if (accept) begin
                skid_d <= s_data;
                skid_v <= 1'b1;
            end
            s_ready <= !((skid_v && !m_ready) ||
                         (main_v && !m_ready && accept));
        end
    end

endmodule

// File: rtl/pfb_input_commutator.sv
// Tags input samples with a descending commutator phase and marks phase 0.
// New arm counts are latched only at frame ends so frames are never split.
module pfb_input_commutator
    import pfb_pkg::*;
#(
    parameter int DATA_WIDTH  = PFB_SAMP_W,
    parameter int PHASE_WIDTH = PFB_PHASE_W
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic [11:0]            num_phases,
    input  logic                   s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    output logic                   s_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   frame_start
);

    localparam int W = DATA_WIDTH + PHASE_WIDTH + 1;

    logic [PHASE_WIDTH-1:0] cnt;
    logic [PHASE_WIDTH:0]   m_nxt;
    logic [PHASE_WIDTH-1:0] reload;
    logic                   accept;
    logic                   out_hs;
    logic                   out_first;
    logic [W-1:0]           in_word;
    logic [W-1:0]           out_word;

    assign m_nxt   = (PHASE_WIDTH+1)'(clamp_phases(num_phases));
    assign reload  = PHASE_WIDTH'(m_nxt - 1'b1);
    assign accept  = s_axis_tvalid & s_axis_tready;
    assign out_hs  = m_axis_tvalid & m_axis_tready;
    assign in_word = {s_axis_tdata, cnt, (cnt == '0)};

    assign {m_axis_tdata, phase, m_axis_tlast} = out_word;

    // Phase counter; reload picks up the arm count present at the frame end.
    always_ff @(posedge clk) begin
        if (sync_reset)
            cnt <= reload;
        else if (accept)
            cnt <= (cnt == '0) ? reload : cnt - 1'b1;
    end

    // Frame start: first beat after reset or after a tlast beat leaves.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            out_first   <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= out_hs & out_first;
            if (out_hs)
                out_first <= m_axis_tlast;
        end
    end

    axis_skid_2 #(
        .WIDTH(W)
    ) u_skid (
        .clk       (clk),
        .sync_reset(sync_reset),
        .s_valid   (s_axis_tvalid),
        .s_data    (in_word),
        .s_ready   (s_axis_tready),
        .m_valid   (m_axis_tvalid),
        .m_data    (out_word),
        .m_ready   (m_axis_tready)
    );

endmodule

// File: tb/tb_pfb_input_commutator.sv
// Scoreboard bench for pfb_input_commutator: frame-level phase model,
// randomized valid/ready, decoupled driver and monitor.
module tb_pfb_input_commutator;

    logic        clk = 1'b0;
    logic        sync_reset = 1'b1;
    logic [11:0] num_phases = 12'd8;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic [10:0] phase;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] d;
        logic [10:0] p;
        logic        l;
        logic        f;
    } exp_t;

    exp_t exp_q[$];
    int   frame_q[$];
    bit   fresh;

    bit          hold = 0;
    logic [31:0] held_d;
    logic [10:0] held_p;
    logic        held_l;
    bit          fs_exp = 0;

    always #5 clk = ~clk;

    pfb_input_commutator dut (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .num_phases   (num_phases),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .phase        (phase),
        .frame_start  (frame_start)
    );

    function automatic int ref_m(input int n);
        if (n < 2) return 2;
        if (n > 2048) return 2048;
        return n;
    endfunction

    // A new frame is the full descending list of phases for the current M.
    function automatic void build_frame();
        int m;
        m = ref_m(int'(num_phases));
        for (int k = m - 1; k >= 0; k--)
            frame_q.push_back(k);
        fresh = 1;
    endfunction

    function automatic void model_accept(input logic [31:0] d);
        exp_t e;
        int   ph;
        ph = frame_q.pop_front();
        e.d = d;
        e.p = 11'(ph);
        e.f = fresh;
        fresh = 0;
        e.l = (frame_q.size() == 0);
        exp_q.push_back(e);
        if (frame_q.size() == 0)
            build_frame();
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req,
                     $time);
        end
    endtask

    // Output-side scoreboard: compare every downstream handshake.
    always @(negedge clk) begin
        #2;
        if (hold) begin
            check("hold_valid", 64'(m_axis_tvalid), 64'd1);
            check("hold_data", {m_axis_tdata, 20'd0, phase, m_axis_tlast},
                  {held_d, 20'd0, held_p, held_l});
        end
        fs_exp = 0;
        if (!sync_reset && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("beat", {m_axis_tdata, 20'd0, phase, m_axis_tlast},
                      {e.d, 20'd0, e.p, e.l});
                fs_exp = e.f;
            end
        end
        hold = !sync_reset && m_axis_tvalid && !m_axis_tready;
        held_d = m_axis_tdata;
        held_p = phase;
        held_l = m_axis_tlast;
    end

    // Post-edge state checks: reset values, occupancy, latency, frame_start.
    always @(posedge clk) begin
        #1;
        if (sync_reset) begin
            check("rst_tready", 64'(s_axis_tready), 64'd0);
            check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
            check("rst_phase", 64'(phase), 64'd0);
            check("rst_tlast", 64'(m_axis_tlast), 64'd0);
            check("rst_fs", 64'(frame_start), 64'd0);
        end else begin
            check("s_tready", 64'(s_axis_tready),
                  64'(exp_q.size() < 2));
            check("m_tvalid", 64'(m_axis_tvalid),
                  64'(exp_q.size() > 0));
            check("frame_start", 64'(frame_start), 64'(fs_exp));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        sync_reset = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        exp_q.delete();
        frame_q.delete();
        @(negedge clk);
        sync_reset = 1'b0;
        build_frame();
    endtask

    // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random.
    task automatic drive(input int n, input int vpct, input int rmode,
                         input int chg_at, input logic [11:0] chg_np);
        int sent = 0;
        int cyc = 0;
        int budget;
        while (sent < n && cyc < n * 20 + 100) begin
            @(negedge clk);
            if (sent == chg_at)
                num_phases = chg_np;
            s_axis_tvalid = ($urandom_range(99) < vpct);
            s_axis_tdata = $urandom;
            case (rmode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: m_axis_tready = $urandom_range(1);
            endcase
            #1;
            if (s_axis_tvalid && s_axis_tready) begin
                model_accept(s_axis_tdata);
                sent++;
            end
            cyc++;
        end
        if (sent < n)
            check("send_timeout", 64'(sent), 64'(n));
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0)
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        num_phases = 12'd8;
        do_reset();
        drive(24, 100, 0, -1, 12'd0);

        num_phases = 12'd8;
        do_reset();
        drive(24, 100, 0, 3, 12'd4);

        num_phases = 12'd5;
        do_reset();
        drive(200, 60, 1, -1, 12'd0);
        drive(200, 70, 2, 50, 12'd3);

        num_phases = 12'd0;
        do_reset();
        drive(12, 80, 2, -1, 12'd0);
        num_phases = 12'd1;
        do_reset();
        drive(12, 80, 2, -1, 12'd0);
        num_phases = 12'd4095;
        do_reset();
        drive(2100, 100, 0, -1, 12'd0);

        num_phases = 12'd16;
        do_reset();
        drive(10, 100, 0, -1, 12'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata = $urandom;
            m_axis_tready = 1'b0;
            #1;
            if (s_axis_tready)
                model_accept(s_axis_tdata);
        end
        check("buffered", 64'(exp_q.size()), 64'd2);
        do_reset();
        drive(20, 90, 2, -1, 12'd0);

        num_phases = 12'd2048;
        do_reset();
        drive(4096, 100, 0, -1, 12'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
